mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between the instruction-cache miss path and the load/store buffer (LSB).
- Accepts one whole request at a time, serialises it into byte beats, and reassembles read data into a 32-bit word.
- Signals completion per requester with a one-cycle done pulse.
- Sits between ic/lsb and the top-level RAM interface.

Parameters:
- AddrWidth, 32, width of every address port.
- DataWidth, 32, width of assembled request data.
- FirstGrantLsb, 1, round-robin pointer value after reset (1 = LSB wins the first tie).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state.
- ic_valid  in  1  icache miss request; held until ic_done.
- ic_addr  in  AddrWidth  fetch address, word aligned.
- lsb_valid  in  1  LSB request; held until lsb_done.
- lsb_addr  in  AddrWidth  byte address.
- lsb_is_store  in  1  1 = store, 0 = load.
- lsb_size  in  2  byte count minus 1; legal values 0, 1, 3.
- lsb_wdata  in  DataWidth  store data, little-endian, low bytes used.
- exception  in  1  ROB flush.
- mem_din  in  8  RAM read byte, valid one cycle after its address.
- mem_a  out  AddrWidth  RAM address.
- mem_dout  out  8  RAM write byte.
- mem_wr  out  1  1 = write.
- ic_done  out  1  one-cycle pulse; ic_data valid.
- ic_data  out  DataWidth  fetched instruction.
- lsb_done  out  1  one-cycle pulse; lsb_data valid for loads.
- lsb_data  out  DataWidth  zero-extended load data; sign extension is the LSB's job.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; mem_a 0, mem_dout 0, mem_wr 0; ic_done 0, lsb_done 0; ic_data 0, lsb_data 0; busy 0; counter 0; round-robin pointer = FirstGrantLsb.
  - Reset asserted mid-transaction aborts it immediately; no done pulse is issued.
- rdy low: no state, counter, pointer or output register changes; mem_wr forced 0 combinationally.
- States:
  - IDLE: if exactly one valid is high, grant it. If both are high, grant per the pointer (1 = LSB), then toggle the pointer. Latch owner, addr, N (4 for ic, lsb_size+1 for lsb), is_store, wdata; counter = 0; go to RD or WR.
  - RD: cycle with counter c drives mem_a = addr + c and mem_wr = 0 while c < N.
    - At each edge with c >= 1, capture mem_din into byte c-1.
    - At the edge with c == N, capture the last byte and go to DONE.
    - A read of N bytes occupies N+1 RD cycles.
  - WR: cycle with counter c drives mem_a = addr + c, mem_dout = wdata byte c, mem_wr = 1.
    - At the edge with c == N-1, go to DONE.
    - Occupies N cycles.
  - DONE: the owner's done output is high for exactly this cycle with data stable; mem_wr = 0; next state IDLE.
    - The requester must deassert valid on the edge where it sees done. IDLE never samples in the DONE cycle, so there is no double grant.
- Addresses are latched at grant. Later changes on *_addr have no effect on the transaction in flight.
- Unused bytes of lsb_data are 0.
- Address increments are AddrWidth-bit modular; wrap at 0xFFFFFFFF -> 0 is permitted.
- exception high (with rdy high):
  - In IDLE: no grant this cycle.
  - In RD (ic or load): abort to IDLE next edge; no done pulse.
  - In WR: the store always completes and lsb_done still pulses, so memory is never torn.
  - In DONE: the pulse is still emitted.
- Illegal lsb_size == 2 is treated as N = 3.

Decomposition:
- parameters.v: state encodings IDLE/RD/WR/DONE, owner encoding (OwnIc/OwnLsb), size macros SizeByte/SizeHalf/SizeWord. Reuse the existing `True/`False/`Zero macros.
- One sub-module, mem_rr_pick: combinational two-requester round-robin pick plus pointer-update signal.
- The byte assembly stays inline in mem_arbiter.

Test Plan:
- ic-only fetch: ic_addr = 0x1000, RAM bytes 13 05 00 00 -> mem_a 0x1000..0x1003 with mem_wr 0; ic_done 5 cycles after grant; ic_data = 0x00000513.
- Word store: lsb 0x2004, size 3, wdata 0xDEADBEEF -> mem_a 0x2004..7 with dout EF BE AD DE, mem_wr 1 for 4 cycles, then lsb_done; a following load of 0x2004 returns 0xDEADBEEF.
- Simultaneous requests from reset: ic and lsb (byte load 0x10) both valid -> LSB served first, ic second; re-raising both afterwards grants ic first.
- Exception during fetch in RD at c = 2 -> IDLE next edge, no ic_done. Exception during WR at c = 1 -> all 4 bytes written, lsb_done pulses.
- rdy held low 3 cycles mid-load -> mem_wr 0, counter frozen; with the RAM model also stalled, the load resumes and the returned data is correct.
- rst pulsed low mid-store -> all outputs 0 immediately; state IDLE; no done pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : State, owner and size encodings shared by the memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic c_OWN_IC  = 1'b0;
    localparam logic c_OWN_LSB = 1'b1;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd3;

    // The unused encoding 2 falls through to a three-byte transfer.
    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        logic [2:0] beats;
        case (size)
            c_SIZE_BYTE: beats = 3'd1;
            c_SIZE_HALF: beats = 3'd2;
            c_SIZE_WORD: beats = 3'd4;
            default:     beats = 3'd3;
        endcase
        return beats;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rr_pick.sv
// ============================================================================
// Module : mem_rr_pick
// Brief  : Two-requester round-robin pick with pointer-toggle request.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_rr_pick (
    input  logic i_ic_req,
    input  logic i_lsb_req,
    input  logic i_ptr_lsb,
    output logic o_grant_ic,
    output logic o_grant_lsb,
    output logic o_toggle
);

    always_comb begin
        o_toggle    = i_ic_req & i_lsb_req;
        o_grant_lsb = i_lsb_req & (~i_ic_req | i_ptr_lsb);
        o_grant_ic  = i_ic_req & (~i_lsb_req | ~i_ptr_lsb);
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares the byte-wide RAM port between icache misses and the LSB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter bit FirstGrantLsb = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 ic_valid,
    input  logic [AddrWidth-1:0] ic_addr,
    input  logic                 lsb_valid,
    input  logic [AddrWidth-1:0] lsb_addr,
    input  logic                 lsb_is_store,
    input  logic [1:0]           lsb_size,
    input  logic [DataWidth-1:0] lsb_wdata,
    input  logic                 exception,
    input  logic [7:0]           mem_din,
    output logic [AddrWidth-1:0] mem_a,
    output logic [7:0]           mem_dout,
    output logic                 mem_wr,
    output logic                 ic_done,
    output logic [DataWidth-1:0] ic_data,
    output logic                 lsb_done,
    output logic [DataWidth-1:0] lsb_data,
    output logic                 busy
);

    logic [1:0]           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_q, rr_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [2:0]           n_q, n_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] buf_q, buf_d;
    logic [AddrWidth-1:0] mem_a_q, mem_a_d;
    logic [7:0]           mem_dout_q, mem_dout_d;
    logic                 mem_wr_q, mem_wr_d;
    logic                 ic_done_q, ic_done_d;
    logic                 lsb_done_q, lsb_done_d;
    logic [DataWidth-1:0] ic_data_q, ic_data_d;
    logic [DataWidth-1:0] lsb_data_q, lsb_data_d;

    logic w_grant_ic;
    logic w_grant_lsb;
    logic w_toggle;

    mem_rr_pick u_rr_pick (
        .i_ic_req    (ic_valid),
        .i_lsb_req   (lsb_valid),
        .i_ptr_lsb   (rr_q),
        .o_grant_ic  (w_grant_ic),
        .o_grant_lsb (w_grant_lsb),
        .o_toggle    (w_toggle)
    );

    // Every output register is loaded one cycle ahead, so the value for
    // beat c is computed at the edge that enters beat c.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        ic_done_d  = ic_done_q;
        lsb_done_d = lsb_done_q;
        ic_data_d  = ic_data_q;
        lsb_data_d = lsb_data_q;

        if (rdy) begin
            ic_done_d  = 1'b0;
            lsb_done_d = 1'b0;
            case (state_q)
                c_ST_IDLE: begin
                    if (!exception && (w_grant_ic || w_grant_lsb)) begin
                        cnt_d  = 3'd0;
                        buf_d  = '0;
                        if (w_toggle) begin
                            rr_d = ~rr_q;
                        end
                        if (w_grant_lsb) begin
                            owner_d    = c_OWN_LSB;
                            addr_d     = lsb_addr;
                            n_d        = beats_for_size(lsb_size);
                            wdata_d    = lsb_wdata;
                            mem_a_d    = lsb_addr;
                            mem_dout_d = lsb_wdata[7:0];
                            mem_wr_d   = lsb_is_store;
                            state_d    = lsb_is_store ? c_ST_WR : c_ST_RD;
                        end else begin
                            owner_d  = c_OWN_IC;
                            addr_d   = ic_addr;
                            n_d      = 3'd4;
                            mem_a_d  = ic_addr;
                            mem_wr_d = 1'b0;
                            state_d  = c_ST_RD;
                        end
                    end
                end
                c_ST_RD: begin
                    if (exception) begin
                        state_d = c_ST_IDLE;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (cnt_q == 3'(i + 1)) begin
                                buf_d[8*i +: 8] = mem_din;
                            end
                        end
                        if (cnt_q == n_q) begin
                            state_d = c_ST_DONE;
                            if (owner_q == c_OWN_IC) begin
                                ic_done_d = 1'b1;
                                ic_data_d = buf_d;
                            end else begin
                                lsb_done_d = 1'b1;
                                lsb_data_d = buf_d;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_d < n_q) begin
                                mem_a_d = addr_q + AddrWidth'(cnt_d);
                            end
                        end
                    end
                end
                c_ST_WR: begin
                    // Stores ignore exception so a partial word is never left in RAM.
                    if (cnt_q == n_q - 3'd1) begin
                        state_d    = c_ST_DONE;
                        mem_wr_d   = 1'b0;
                        lsb_done_d = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 3'd1;
                        mem_a_d  = addr_q + AddrWidth'(cnt_d);
                        mem_wr_d = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            if (cnt_d == 3'(i)) begin
                                mem_dout_d = wdata_q[8*i +: 8];
                            end
                        end
                    end
                end
                default: begin
                    state_d = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= c_ST_IDLE;
            owner_q    <= c_OWN_IC;
            rr_q       <= FirstGrantLsb;
            addr_q     <= '0;
            n_q        <= 3'd0;
            cnt_q      <= 3'd0;
            wdata_q    <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            ic_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            ic_data_q  <= '0;
            lsb_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            ic_done_q  <= ic_done_d;
            lsb_done_q <= lsb_done_d;
            ic_data_q  <= ic_data_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q & rdy;
    assign ic_done  = ic_done_q;
    assign lsb_done = lsb_done_q;
    assign ic_data  = ic_data_q;
    assign lsb_data = lsb_data_q;
    assign busy     = (state_q != c_ST_IDLE);

endmodule

`default_nettype wire
